// File: rtl/mlp_pkg.sv
// Shared types and helpers for the time-multiplexed MLP classifier (mlp_seq).
package mlp_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HID,
        ST_OUT,
        ST_DONE
    } state_e;

    // Accumulator operations: keep, clear, load addend, add addend
    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_CLR,
        MAC_LOAD,
        MAC_ACC
    } mac_op_e;

    // Ceiling log2, never below 1 so counters always have at least one bit
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p * 2;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // First output-layer weight address
    function automatic int unsigned w2_base(input int unsigned n_in, input int unsigned n_hid);
        return n_hid * (n_in + 1);
    endfunction

    // Output bias address
    function automatic int unsigned b2_addr(input int unsigned n_in, input int unsigned n_hid);
        return w2_base(n_in, n_hid) + n_hid;
    endfunction

endpackage

// File: rtl/mlp_seq_if.sv
// Sample/decision handshakes and weight-write port of mlp_seq.
interface mlp_seq_if #(
    parameter int unsigned N_IN = 2,
    parameter int unsigned DW   = 10,
    parameter int unsigned WW   = 8,
    parameter int unsigned AW   = 4
) ();
    logic [N_IN*DW-1:0] x_in;
    logic               in_valid;
    logic               in_ready;
    logic               y;
    logic               out_valid;
    logic               out_ready;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WW-1:0]      wr_data;
    logic               busy;

    modport master (
        output x_in, in_valid, out_ready, wr_en, wr_addr, wr_data,
        input  in_ready, y, out_valid, busy
    );

    modport slave (
        input  x_in, in_valid, out_ready, wr_en, wr_addr, wr_data,
        output in_ready, y, out_valid, busy
    );
endinterface

// File: rtl/mlp_mac.sv
// Shared signed multiply-accumulate; bias mode adds the sign-extended weight unscaled.
module mlp_mac
    import mlp_pkg::*;
#(
    parameter int unsigned DW    = 10,
    parameter int unsigned WW    = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  mac_op_e                 op_i,
    input  logic                    bias_i,
    input  logic signed [DW-1:0]    a_i,
    input  logic signed [WW-1:0]    b_i,
    output logic signed [ACC_W-1:0] acc_o
);
    localparam int unsigned PW = DW + WW;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;

    assign prod   = PW'(a_i) * PW'(b_i);
    assign addend = bias_i ? {{(ACC_W-WW){b_i[WW-1]}}, b_i}
                           : {{(ACC_W-PW){prod[PW-1]}}, prod};

    // Next accumulator value
    always_comb begin
        acc_d = acc_q;
        case (op_i)
            MAC_CLR:  acc_d = '0;
            MAC_LOAD: acc_d = addend;
            MAC_ACC:  acc_d = acc_q + addend;
            default:  acc_d = acc_q;
        endcase
    end

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/mlp_seq.sv
// Time-multiplexed N_IN -> N_HID -> 1 MLP classifier with writable weights.
// Optional macro MLP_RELU_EN: ReLU hidden activation (DW-bit h) instead of 1-bit step.
module mlp_seq
    import mlp_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_HID = 2,
    parameter int unsigned DW    = 10,
    parameter int unsigned WW    = 8,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned AW    = 4
) (
    input logic      clk,
    input logic      rst,
    mlp_seq_if.slave mlp_if
);
    localparam int unsigned XBITS = N_IN * DW;
    localparam int unsigned W2B   = w2_base(N_IN, N_HID);
    localparam int unsigned NW    = b2_addr(N_IN, N_HID) + 1;
    localparam int unsigned NREG  = 2 ** AW;
    localparam int unsigned KW    = clog2(N_IN + 1);
    localparam int unsigned JW    = clog2(N_HID);
    localparam int unsigned PCW   = clog2(N_HID + 3);
`ifdef MLP_RELU_EN
    localparam int unsigned HW    = DW;
`else
    localparam int unsigned HW    = 1;
`endif
    localparam int unsigned HBITS = N_HID * HW;

    state_e                  state_q;
    logic [KW-1:0]           k_q;
    logic [JW-1:0]           j_q;
    logic [PCW-1:0]          p_q;
    logic [XBITS-1:0]        x_q;
    logic [HBITS-1:0]        h_q;
    logic                    y_q;
    logic                    out_valid_q;
    logic signed [WW-1:0]    wgt_q [NREG];

    mac_op_e                 mac_op_c;
    logic                    mac_bias_c;
    logic signed [DW-1:0]    mac_a_c;
    logic signed [WW-1:0]    mac_b_c;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_pos_c;
    logic [HW-1:0]           act_c;
    logic [AW-1:0]           hid_addr_c;
    logic [AW-1:0]           out_addr_c;
    logic                    wr_ok_c;

    mlp_mac #(.DW(DW), .WW(WW), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .op_i   (mac_op_c),
        .bias_i (mac_bias_c),
        .a_i    (mac_a_c),
        .b_i    (mac_b_c),
        .acc_o  (acc)
    );

    assign acc_pos_c = !acc[ACC_W-1] && (acc != '0);

    // Hidden activation of the registered accumulator
`ifdef MLP_RELU_EN
    always_comb begin
        act_c = '0;
        if (acc_pos_c)
            act_c = (acc[ACC_W-2:DW-1] != '0) ? {1'b0, {(DW-1){1'b1}}} : acc[DW-1:0];
    end
`else
    assign act_c = acc_pos_c;
`endif

    // Weight addresses: p=1..N_HID walks W2, p=N_HID+1 lands on B2
    assign hid_addr_c = AW'(32'(j_q) * (N_IN + 1) + 32'(k_q));
    assign out_addr_c = AW'(W2B + 32'(p_q) - 1);
    assign wr_ok_c    = mlp_if.wr_en && (state_q == ST_IDLE) && !out_valid_q
                        && (32'(mlp_if.wr_addr) < NW);

    // MAC operand and operation selection
    always_comb begin
        mac_op_c   = MAC_HOLD;
        mac_bias_c = 1'b0;
        mac_a_c    = x_q[DW-1:0];
        mac_b_c    = wgt_q[hid_addr_c];
        case (state_q)
            ST_HID: begin
                mac_bias_c = (k_q == KW'(N_IN));
                mac_op_c   = (k_q == '0) ? MAC_LOAD : MAC_ACC;
            end
            ST_OUT: begin
                mac_b_c = wgt_q[out_addr_c];
                if (p_q == '0) begin
                    mac_op_c = MAC_CLR;
                end else if (32'(p_q) <= N_HID) begin
                    mac_op_c = MAC_ACC;
`ifdef MLP_RELU_EN
                    mac_a_c = h_q[HW-1:0];
`else
                    mac_bias_c = 1'b1;
                    if (!h_q[0]) mac_b_c = '0;
`endif
                end else if (32'(p_q) == N_HID + 1) begin
                    mac_op_c   = MAC_ACC;
                    mac_bias_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequencer, sample/hidden registers, weight file and registered outputs.
    // Activation reads the registered accumulator one step after the bias add,
    // overlapping with the next neuron's first product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            p_q         <= '0;
            x_q         <= '0;
            h_q         <= '0;
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
            for (int n = 0; n < int'(NREG); n++) wgt_q[n] <= '0;
        end else begin
            if (wr_ok_c) wgt_q[mlp_if.wr_addr] <= mlp_if.wr_data;
            case (state_q)
                ST_IDLE: begin
                    if (mlp_if.in_valid) begin
                        x_q     <= mlp_if.x_in;
                        k_q     <= '0;
                        j_q     <= '0;
                        state_q <= ST_HID;
                    end
                end
                ST_HID: begin
                    if (k_q == KW'(N_IN)) begin
                        k_q <= '0;
                        if (j_q == JW'(N_HID - 1)) begin
                            j_q     <= '0;
                            p_q     <= '0;
                            state_q <= ST_OUT;
                        end else begin
                            j_q <= j_q + JW'(1);
                        end
                    end else begin
                        k_q <= k_q + KW'(1);
                        x_q <= XBITS'({x_q, x_q} >> DW);
                        if (k_q == '0 && j_q != '0) h_q <= HBITS'({act_c, h_q} >> HW);
                    end
                end
                ST_OUT: begin
                    p_q <= p_q + PCW'(1);
                    if (p_q == '0) begin
                        h_q <= HBITS'({act_c, h_q} >> HW);
                    end else if (32'(p_q) <= N_HID) begin
                        h_q <= HBITS'({h_q, h_q} >> HW);
                    end else if (32'(p_q) == N_HID + 2) begin
                        y_q         <= acc_pos_c;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (mlp_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mlp_if.y         = y_q;
    assign mlp_if.out_valid = out_valid_q;
    assign mlp_if.in_ready  = !rst && (state_q == ST_IDLE) && !out_valid_q;
    assign mlp_if.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mlp_seq.sv
// Scoreboard bench for mlp_seq: model results queued on accept, compared on out_valid rise.
module tb_mlp_seq;
    localparam int unsigned N_IN    = 2;
    localparam int unsigned N_HID   = 2;
    localparam int unsigned DW      = 10;
    localparam int unsigned WW      = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned AW      = 4;
    localparam int          NW      = 9;
    localparam int          LATENCY = 11;

    typedef struct {
        int y;
        int acc_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    bit   ov_prev;
    exp_t exp_q[$];
    int   mw[NW];

    mlp_seq_if #(.N_IN(N_IN), .DW(DW), .WW(WW), .AW(AW)) ifc ();

    mlp_seq #(
        .N_IN(N_IN), .N_HID(N_HID), .DW(DW), .WW(WW), .ACC_W(ACC_W), .AW(AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mlp_if (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_y(input int x0, input int x1);
        int xs[N_IN];
        int h[N_HID];
        int acc;
        xs[0] = x0;
        xs[1] = x1;
        for (int j = 0; j < N_HID; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) acc += xs[i] * mw[j*(N_IN+1)+i];
            acc += mw[j*(N_IN+1)+N_IN];
`ifdef MLP_RELU_EN
            h[j] = (acc <= 0) ? 0 : ((acc > 511) ? 511 : acc);
`else
            h[j] = (acc > 0) ? 1 : 0;
`endif
        end
        acc = 0;
        for (int j = 0; j < N_HID; j++) acc += h[j] * mw[N_HID*(N_IN+1)+j];
        acc += mw[NW-1];
        return (acc > 0) ? 1 : 0;
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < NW; a++) mw[a] = 0;
    endfunction

    // Output monitor: pop the oldest expectation on each out_valid rise
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (ifc.out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y", ifc.y, e.y);
                    check("latency", cyc - e.acc_edge, LATENCY);
                end
            end
            ov_prev = ifc.out_valid;
        end
    end

    task automatic wr(input int a, input int d, input bit takes_effect);
        @(negedge clk);
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = AW'(a);
        ifc.wr_data = WW'(d);
        @(negedge clk);
        ifc.wr_en = 1'b0;
        if (takes_effect && a < NW) mw[a] = d;
    endtask

    task automatic send(input int x0, input int x1);
        int n;
        n = 0;
        @(negedge clk);
        ifc.x_in     = {DW'(x1), DW'(x0)};
        ifc.in_valid = 1'b1;
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.in_ready) begin
            check("accept_timeout", 0, 1);
            ifc.in_valid = 1'b0;
        end else begin
            exp_q.push_back('{y: model_y(x0, x1), acc_edge: cyc + 1});
            @(posedge clk);
            #1 ifc.in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && ifc.in_ready) && n < 200);
        if (!(exp_q.size() == 0 && ifc.in_ready)) check("drain_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int x0, input int x1);
        send(x0, x1);
        wait_drain();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        int  y0;
        bit  stable;

        clk = 1'b0;
        rst = 1'b1;
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        ifc.in_valid  = 1'b0;
        ifc.x_in      = '0;
        ifc.out_ready = 1'b1;
        ifc.wr_en     = 1'b0;
        ifc.wr_addr   = '0;
        ifc.wr_data   = '0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_y", ifc.y, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("in_ready_after_rst", ifc.in_ready, 1);

        // Abort mid-inference; reset must also clear the B2 written beforehand
        wr(NW - 1, 1, 1'b1);
        send(1, 1);
        repeat (4) @(negedge clk);
        check("busy_mid", ifc.busy, 1);
        rst = 1'b1;
        exp_q.delete();
        model_clear();
        #1;
        check("abort_out_valid", ifc.out_valid, 0);
        check("abort_busy", ifc.busy, 0);
        check("abort_y", ifc.y, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_output", ifc.out_valid, 0);
        run(3, 2);

        // XOR-style network
        begin
            int wv[NW] = '{1, -1, 0, -1, 1, 0, 1, 1, 0};
            for (int a = 0; a < NW; a++) wr(a, wv[a], 1'b1);
        end
        run(5, -3);
        run(-2, 4);
        run(0, 0);
        run(7, -1);

        // Backpressure, then a sample offered while DONE is released
        ifc.out_ready = 1'b0;
        send(5, -3);
        n = 0;
        while (!ifc.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", ifc.out_valid, 1);
        y0 = ifc.y;
        stable = 1'b1;
        ifc.x_in     = {DW'(-1), DW'(7)};
        ifc.in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(ifc.out_valid && !ifc.in_ready && ifc.y == y0[0])) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ov_drop", ifc.out_valid, 0);
        check("bp_in_ready", ifc.in_ready, 1);
        check("bp_not_accepted", ifc.busy, 0);
        exp_q.push_back('{y: model_y(7, -1), acc_edge: cyc + 1});
        @(posedge clk);
        #1 ifc.in_valid = 1'b0;
        wait_drain();

        // Weight write during HID is dropped; the same write in IDLE lands
        send(5, -3);
        @(negedge clk);
        check("busy_hid", ifc.busy, 1);
        wr(6, -5, 1'b0);
        wait_drain();
        wr(6, -5, 1'b1);
        run(5, -3);

        // Output bias boundary and out-of-range address
        do_reset();
        run(3, -2);
        wr(NW - 1, 1, 1'b1);
        run(3, -2);
        wr(15, -100, 1'b1);
        run(3, -2);

        // Magnitude-sensitive network (ReLU hidden path when enabled)
        do_reset();
        begin
            int wv[NW] = '{2, 0, 0, 0, 0, 0, 1, 0, -9};
            for (int a = 0; a < NW; a++) wr(a, wv[a], 1'b1);
        end
        run(5, 0);
        run(4, 0);

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
